// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared widths and glyph table for the seven-segment counter
package seven_seg_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  localparam logic [SEG_W-1:0] BLANK = 7'h00;

  // bit0 = a .. bit6 = g, active-high
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational nibble to seven-segment glyph with blanking
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = GLYPH[digit];
    if (blank) begin
      seg = BLANK;
    end
  end

endmodule

// File: rtl/seven_seg_mux_counter.sv
// rtl/seven_seg_mux_counter.sv - multi-digit BCD/hex up/down counter with multiplexed seven-segment scan
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_mux_counter
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int REFRESH_DIV = 10_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_ena,
  input  logic                          io_run,
  input  logic                          io_down,
  input  logic                          io_bcd,
  input  logic                          io_load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] io_loadValue,
  output logic [SEG_W-1:0]              io_sevenSeg,
  output logic [NUM_DIGITS-1:0]         io_digitSel,
  output logic                          io_tick,
  output logic [DIGIT_W*NUM_DIGITS-1:0] io_count
);

  localparam int CW = DIGIT_W * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] SCAN_MAX    = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RW-1:0]         refresh_q, refresh_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;

  logic [CW-1:0]         count_step;
  logic                  carry;
  logic [DIGIT_W-1:0]    dig;
  logic [DIGIT_W-1:0]    nd;
  logic [DIGIT_W-1:0]    digit_max;

  logic [DIGIT_W-1:0]    cur_digit;
  logic [NUM_DIGITS-1:0] cur_onehot;
  logic                  cur_blank;
  logic [SEG_W-1:0]      dec_seg;

  // Ripple the +/-1 through the digits; in BCD anything >= 9 rolls over on an up step.
  always_comb begin
    count_step = count_q;
    carry      = 1'b1;
    dig        = '0;
    nd         = '0;
    digit_max  = io_bcd ? 4'd9 : 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = count_q[i*DIGIT_W +: DIGIT_W];
      nd  = dig;
      if (carry) begin
        if (!io_down) begin
          if (dig >= digit_max) begin
            nd = '0;
          end else begin
            nd    = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nd = digit_max;
          end else begin
            nd    = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      count_step[i*DIGIT_W +: DIGIT_W] = nd;
    end
  end

  always_comb begin
    cur_digit  = '0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        cur_digit     = count_q[i*DIGIT_W +: DIGIT_W];
        cur_onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;

  // zero_from[i] is set when digit i and all digits above it are zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    cur_blank = 1'b0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zero_acc     = zero_acc & (count_q[j*DIGIT_W +: DIGIT_W] == 4'd0);
      zero_from[j] = zero_acc;
    end
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if (scan_idx_q == IW'(j) && zero_from[j]) begin
        cur_blank = 1'b1;
      end
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  seven_seg_decoder u_decoder (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    presc_d    = presc_q;
    tick_d     = tick_q;
    count_d    = count_q;
    refresh_d  = refresh_q;
    scan_idx_d = scan_idx_q;
    sel_d      = sel_q;
    seg_d      = seg_q;
    if (io_ena) begin
      tick_d  = (presc_q == PRESC_MAX);
      presc_d = tick_d ? '0 : presc_q + PW'(1);

      if (io_load) begin
        count_d = io_loadValue;
      end else if (tick_q && io_run) begin
        count_d = count_step;
      end

      if (refresh_q == REFRESH_MAX) begin
        refresh_d  = '0;
        scan_idx_d = (scan_idx_q == SCAN_MAX) ? '0 : scan_idx_q + IW'(1);
      end else begin
        refresh_d = refresh_q + RW'(1);
      end

      sel_d = cur_onehot;
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      count_q    <= '0;
      refresh_q  <= '0;
      scan_idx_q <= '0;
      sel_q      <= NUM_DIGITS'(1);
      seg_q      <= GLYPH[0];
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      count_q    <= count_d;
      refresh_q  <= refresh_d;
      scan_idx_q <= scan_idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  // A pending tick survives a freeze but is never shown while disabled.
  assign io_tick     = tick_q & io_ena;
  assign io_count    = count_q;
  assign io_digitSel = sel_q;
  assign io_sevenSeg = seg_q;

endmodule

// File: tb/tb_seven_seg_mux_counter.sv
// tb/tb_seven_seg_mux_counter.sv - directed bench for seven_seg_mux_counter (honours LEADING_ZERO_BLANK_EN)
module tb_seven_seg_mux_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        run = 1'b0;
  logic        down = 1'b0;
  logic        bcd = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic        tick;
  logic [15:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] GLY [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  seven_seg_mux_counter #(
    .NUM_DIGITS  (4),
    .TICK_DIV    (4),
    .REFRESH_DIV (2)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .io_ena       (ena),
    .io_run       (run),
    .io_down      (down),
    .io_bcd       (bcd),
    .io_load      (load),
    .io_loadValue (load_val),
    .io_sevenSeg  (seg),
    .io_digitSel  (sel),
    .io_tick      (tick),
    .io_count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %h expected 0000", count); end
    n_cmp++; if (sel !== 4'b0001) begin n_bad++; $display("FAIL reset_sel: got %b expected 0001", sel); end
    n_cmp++; if (seg !== 7'h3F) begin n_bad++; $display("FAIL reset_seg: got %h expected 3f", seg); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b expected 0", tick); end
  endtask

  task automatic test_count();
    run = 1'b1; bcd = 1'b1; down = 1'b0; load = 1'b0;
    do_reset();
    for (int c = 1; c <= 44; c++) begin
      step();
      n_cmp++;
      if (tick !== ((c % 4) == 0)) begin
        n_bad++; $display("FAIL count_tick cycle %0d: got %b expected %b", c, tick, (c % 4) == 0);
      end
      if (c == 37) begin
        n_cmp++; if (count !== 16'h0009) begin n_bad++; $display("FAIL count_9: got %h expected 0009", count); end
      end
      if (c == 41) begin
        n_cmp++; if (count !== 16'h0010) begin n_bad++; $display("FAIL count_10: got %h expected 0010", count); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v_ld  [8] = '{16'h9999, 16'h0000, 16'hFFFF, 16'h0000, 16'h0199, 16'h1000, 16'h00F0, 16'h000A};
    logic [15:0] v_exp [8] = '{16'h0000, 16'h9999, 16'h0000, 16'hFFFF, 16'h0200, 16'h0999, 16'h00EF, 16'h0010};
    logic        v_dn  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        v_bcd [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      run = 1'b1; down = v_dn[k]; bcd = v_bcd[k]; load = 1'b0;
      do_reset();
      load = 1'b1; load_val = v_ld[k];
      step();
      load = 1'b0;
      n_cmp++; if (count !== v_ld[k]) begin n_bad++; $display("FAIL wrap_load case %0d: got %h expected %h", k, count, v_ld[k]); end
      step(); step(); step();
      n_cmp++; if (tick !== 1'b1 || count !== v_ld[k]) begin
        n_bad++; $display("FAIL wrap_pre case %0d: got tick %b count %h expected tick 1 count %h", k, tick, count, v_ld[k]);
      end
      step();
      n_cmp++; if (count !== v_exp[k]) begin n_bad++; $display("FAIL wrap_step case %0d: got %h expected %h", k, count, v_exp[k]); end
    end
  endtask

  task automatic test_load_priority();
    run = 1'b1; bcd = 1'b1; down = 1'b0; load = 1'b0;
    do_reset();
    step(); step(); step(); step();
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL prio_tick: got %b expected 1", tick); end
    load = 1'b1; load_val = 16'h1234;
    step();
    load = 1'b0;
    n_cmp++; if (count !== 16'h1234) begin n_bad++; $display("FAIL prio_load: got %h expected 1234", count); end
    step(); step(); step();
    n_cmp++; if (count !== 16'h1234 || tick !== 1'b1) begin
      n_bad++; $display("FAIL prio_hold: got count %h tick %b expected 1234 1", count, tick);
    end
    step();
    n_cmp++; if (count !== 16'h1235) begin n_bad++; $display("FAIL prio_next: got %h expected 1235", count); end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    int          idx;
    logic [3:0]  nib;
    v = 16'h1234;
    run = 1'b0; bcd = 1'b1; load = 1'b0;
    do_reset();
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
    step();
    for (int e = 3; e <= 10; e++) begin
      step();
      idx = ((e - 1) / 2) % 4;
      nib = v[idx*4 +: 4];
      n_cmp++; if (sel !== 4'(1 << idx)) begin n_bad++; $display("FAIL scan_sel edge %0d: got %b expected %b", e, sel, 4'(1 << idx)); end
      n_cmp++; if (seg !== GLY[nib]) begin n_bad++; $display("FAIL scan_seg edge %0d: got %h expected %h", e, seg, GLY[nib]); end
    end
  endtask

  task automatic test_blank();
    int         idx;
    logic [6:0] exp_seg;
    run = 1'b0; bcd = 1'b1; load = 1'b0;
    do_reset();
    load = 1'b1; load_val = 16'h0007;
    step();
    load = 1'b0;
    step();
    for (int e = 3; e <= 10; e++) begin
      step();
      idx = ((e - 1) / 2) % 4;
      exp_seg = (idx == 0) ? 7'h07 : LZ;
      n_cmp++; if (sel !== 4'(1 << idx) || seg !== exp_seg) begin
        n_bad++; $display("FAIL blank edge %0d: got sel %b seg %h expected sel %b seg %h", e, sel, seg, 4'(1 << idx), exp_seg);
      end
    end
  endtask

  task automatic test_ena();
    run = 1'b1; bcd = 1'b1; down = 1'b0; load = 1'b0; ena = 1'b1;
    do_reset();
    step(); step(); step(); step(); step();
    n_cmp++; if (count !== 16'h0001) begin n_bad++; $display("FAIL ena_pre: got %h expected 0001", count); end
    ena = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (tick !== 1'b0 || count !== 16'h0001 || sel !== 4'b0100 || seg !== LZ) begin
        n_bad++; $display("FAIL ena_frozen cycle %0d: got tick %b count %h sel %b seg %h expected 0 0001 0100 %h", k, tick, count, sel, seg, LZ);
      end
    end
    ena = 1'b1;
    step();
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL ena_resume1: got %b expected 0", tick); end
    step();
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL ena_resume2: got %b expected 0", tick); end
    step();
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL ena_resume3: got %b expected 1", tick); end
    step();
    n_cmp++; if (count !== 16'h0002) begin n_bad++; $display("FAIL ena_resume_count: got %h expected 0002", count); end
  endtask

  task automatic test_async_reset();
    step();
    rst = 1'b1;
    #2;
    n_cmp++; if (count !== 16'h0000 || sel !== 4'b0001 || seg !== 7'h3F || tick !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got count %h sel %b seg %h tick %b expected 0000 0001 3f 0", count, sel, seg, tick);
    end
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_cmp++; if (tick !== ((c % 4) == 0)) begin
        n_bad++; $display("FAIL post_reset_tick cycle %0d: got %b expected %b", c, tick, (c % 4) == 0);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_count();
    test_wrap();
    test_load_priority();
    test_scan();
    test_blank();
    test_ena();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
